// File: rtl/rv_ctrl_pkg.sv
// ============================================================================
// Module   : rv_ctrl_pkg
// Purpose  : Shared encodings for the multicycle RV32 control path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_DECODE  = 3'd1,
      ST_EXEC    = 3'd2,
      ST_MEM     = 3'd3,
      ST_WB      = 3'd4,
      ST_MULWAIT = 3'd5,
      ST_TRAP    = 3'd6
   } state_t;

   typedef enum logic [3:0] {
      CLS_NONE, CLS_ALU_R, CLS_ALU_I, CLS_UPPER, CLS_LOAD,
      CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_MUL
   } instr_class_t;

   localparam logic [6:0] c_op_r      = 7'b0110011;
   localparam logic [6:0] c_op_i      = 7'b0010011;
   localparam logic [6:0] c_op_load   = 7'b0000011;
   localparam logic [6:0] c_op_store  = 7'b0100011;
   localparam logic [6:0] c_op_branch = 7'b1100011;
   localparam logic [6:0] c_op_jal    = 7'b1101111;
   localparam logic [6:0] c_op_jalr   = 7'b1100111;
   localparam logic [6:0] c_op_lui    = 7'b0110111;
   localparam logic [6:0] c_op_auipc  = 7'b0010111;

   localparam logic [3:0] c_alu_add   = 4'b0000;
   localparam logic [3:0] c_alu_sub   = 4'b0001;
   localparam logic [3:0] c_alu_and   = 4'b0010;
   localparam logic [3:0] c_alu_or    = 4'b0011;
   localparam logic [3:0] c_alu_xor   = 4'b0100;
   localparam logic [3:0] c_alu_sll   = 4'b0101;
   localparam logic [3:0] c_alu_srl   = 4'b0110;
   localparam logic [3:0] c_alu_sra   = 4'b0111;
   localparam logic [3:0] c_alu_slt   = 4'b1000;
   localparam logic [3:0] c_alu_sltu  = 4'b1001;
   localparam logic [3:0] c_alu_mul   = 4'b1010;

   localparam logic [1:0] c_pc_plus4   = 2'b00;
   localparam logic [1:0] c_pc_imm     = 2'b01;
   localparam logic [1:0] c_pc_rs1_imm = 2'b10;

   // alt selects SUB (funct3 000) or SRA (funct3 101)
   function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
      logic [3:0] op;
      case (f3)
         3'b000:  op = alt ? c_alu_sub : c_alu_add;
         3'b001:  op = c_alu_sll;
         3'b010:  op = c_alu_slt;
         3'b011:  op = c_alu_sltu;
         3'b100:  op = c_alu_xor;
         3'b101:  op = alt ? c_alu_sra : c_alu_srl;
         3'b110:  op = c_alu_or;
         default: op = c_alu_and;
      endcase
      return op;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rv_decode.sv
// ============================================================================
// Module   : rv_decode
// Purpose  : Combinational opcode/funct decode into ALU op, class and legality.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_decode
   import rv_ctrl_pkg::*;
#(
   parameter int ENABLE_M = 0
) (
   input  logic [6:0]   opcode,
   input  logic [2:0]   funct3,
   input  logic [6:0]   funct7,
   output logic [3:0]   alu_op,
   output instr_class_t cls,
   output logic         legal
);

   always_comb begin
      alu_op = c_alu_add;
      cls    = CLS_NONE;
      legal  = 1'b0;
      case (opcode)
         c_op_r: begin
            case (funct7)
               7'h00: begin
                  cls    = CLS_ALU_R;
                  legal  = 1'b1;
                  alu_op = alu_from_funct3(funct3, 1'b0);
               end
               7'h20: begin
                  cls    = CLS_ALU_R;
                  legal  = (funct3 == 3'b000) || (funct3 == 3'b101);
                  alu_op = alu_from_funct3(funct3, 1'b1);
               end
               7'h01: begin
                  // Only MUL..MULHU exist; the divide half stays illegal
                  cls    = CLS_MUL;
                  legal  = (ENABLE_M != 0) && !funct3[2];
                  alu_op = c_alu_mul + {2'b00, funct3[1:0]};
               end
               default: ;
            endcase
         end
         c_op_i: begin
            cls    = CLS_ALU_I;
            legal  = 1'b1;
            alu_op = alu_from_funct3(funct3, (funct3 == 3'b101) && (funct7 == 7'h20));
         end
         c_op_load:   begin cls = CLS_LOAD;   legal = 1'b1; end
         c_op_store:  begin cls = CLS_STORE;  legal = 1'b1; end
         c_op_branch: begin cls = CLS_BRANCH; legal = 1'b1; alu_op = c_alu_sub; end
         c_op_jal:    begin cls = CLS_JAL;    legal = 1'b1; end
         c_op_jalr:   begin cls = CLS_JALR;   legal = 1'b1; end
         c_op_lui,
         c_op_auipc:  begin cls = CLS_UPPER;  legal = 1'b1; end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Multicycle RV32I(+M) control FSM with memory wait timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
   import rv_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int ENABLE_M    = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       mem_ready,
   input  logic       branch_taken,
   input  logic       mul_done,
   input  logic       trap_ack,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic       mem_req,
   output logic       mem_we,
   output logic       mem_is_instr,
   output logic       mem_to_reg,
   output logic       alu_src,
   output logic       mul_start,
   output logic [3:0] alu_op,
   output logic [1:0] pc_src,
   output logic       illegal,
   output logic [2:0] state_o
);

   localparam logic [7:0] c_cnt_limit = 8'(MEM_TIMEOUT - 1);

   state_t       r_state;
   logic [7:0]   r_wait_cnt;
   logic [3:0]   w_alu_op;
   instr_class_t w_cls;
   logic         w_legal;
   logic         w_timeout;

   rv_decode #(.ENABLE_M(ENABLE_M)) u_decode (
      .opcode (opcode),
      .funct3 (funct3),
      .funct7 (funct7),
      .alu_op (w_alu_op),
      .cls    (w_cls),
      .legal  (w_legal)
   );

   assign w_timeout = (r_wait_cnt == c_cnt_limit);
   assign state_o   = r_state;

   // Counter is cleared on every transition; a ready in the limit cycle wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_FETCH;
         r_wait_cnt <= 8'd0;
      end else begin
         case (r_state)
            ST_FETCH, ST_MEM: begin
               if (mem_ready) begin
                  r_wait_cnt <= 8'd0;
                  if (r_state == ST_FETCH)   r_state <= ST_DECODE;
                  else if (w_cls == CLS_LOAD) r_state <= ST_WB;
                  else                        r_state <= ST_FETCH;
               end else if (w_timeout) begin
                  r_wait_cnt <= 8'd0;
                  r_state    <= ST_TRAP;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 8'd1;
               end
            end
            ST_DECODE: begin
               r_wait_cnt <= 8'd0;
               r_state    <= w_legal ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
               r_wait_cnt <= 8'd0;
               case (w_cls)
                  CLS_ALU_R, CLS_ALU_I, CLS_UPPER: r_state <= ST_WB;
                  CLS_LOAD, CLS_STORE:             r_state <= ST_MEM;
                  CLS_MUL:                         r_state <= ST_MULWAIT;
                  default:                         r_state <= ST_FETCH;
               endcase
            end
            ST_MULWAIT: begin
               r_wait_cnt <= 8'd0;
               if (mul_done) r_state <= ST_WB;
            end
            ST_WB: begin
               r_wait_cnt <= 8'd0;
               r_state    <= ST_FETCH;
            end
            ST_TRAP: begin
               r_wait_cnt <= 8'd0;
               if (trap_ack) r_state <= ST_FETCH;
            end
            default: begin
               r_wait_cnt <= 8'd0;
               r_state    <= ST_FETCH;
            end
         endcase
      end
   end

   // Outputs are forced low while reset is held, even though the state reads FETCH
   always_comb begin
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      reg_write    = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_is_instr = 1'b0;
      mem_to_reg   = 1'b0;
      alu_src      = 1'b0;
      mul_start    = 1'b0;
      alu_op       = c_alu_add;
      pc_src       = c_pc_plus4;
      illegal      = 1'b0;
      if (rst_n) begin
         case (r_state)
            ST_FETCH: begin
               mem_req      = 1'b1;
               mem_is_instr = 1'b1;
               ir_write     = mem_ready;
            end
            ST_EXEC: begin
               case (w_cls)
                  CLS_ALU_R: alu_op = w_alu_op;
                  CLS_ALU_I, CLS_UPPER, CLS_LOAD, CLS_STORE: begin
                     alu_op  = w_alu_op;
                     alu_src = 1'b1;
                  end
                  CLS_BRANCH: begin
                     alu_op   = c_alu_sub;
                     pc_write = 1'b1;
                     pc_src   = branch_taken ? c_pc_imm : c_pc_plus4;
                  end
                  CLS_JAL, CLS_JALR: begin
                     reg_write = 1'b1;
                     pc_write  = 1'b1;
                     pc_src    = (w_cls == CLS_JAL) ? c_pc_imm : c_pc_rs1_imm;
                  end
                  CLS_MUL: begin
                     alu_op    = w_alu_op;
                     mul_start = 1'b1;
                  end
                  default: ;
               endcase
            end
            ST_MEM: begin
               mem_req  = 1'b1;
               mem_we   = (w_cls == CLS_STORE);
               pc_write = mem_ready && (w_cls == CLS_STORE);
            end
            ST_MULWAIT: alu_op = w_alu_op;
            ST_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = (w_cls == CLS_LOAD);
               pc_write   = 1'b1;
            end
            ST_TRAP: illegal = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module   : tb_multicycle_ctrl
// Purpose  : Scoreboard bench for multicycle_ctrl (M-enabled and M-disabled copies).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

   // Strobe bit positions inside the packed expected vector
   localparam logic [9:0] c_irw = 10'h200, c_pcw = 10'h100, c_rw  = 10'h080,
                          c_req = 10'h040, c_we  = 10'h020, c_ins = 10'h010,
                          c_m2r = 10'h008, c_src = 10'h004, c_mst = 10'h002,
                          c_ill = 10'h001;
   localparam logic [9:0] c_none = 10'h000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       mem_ready, branch_taken, mul_done, trap_ack;

   logic       ir_write, pc_write, reg_write, mem_req, mem_we, mem_is_instr;
   logic       mem_to_reg, alu_src, mul_start, illegal;
   logic [3:0] alu_op;
   logic [1:0] pc_src;
   logic [2:0] state_o;

   logic       n_ir_write, n_pc_write, n_reg_write, n_mem_req, n_mem_we, n_mem_is_instr;
   logic       n_mem_to_reg, n_alu_src, n_mul_start, n_illegal;
   logic [3:0] n_alu_op;
   logic [1:0] n_pc_src;
   logic [2:0] n_state_o;

   int checks = 0;
   int errors = 0;

   logic [18:0] q_vec[$];
   logic [2:0]  q_st0[$];
   string       q_name[$];

   multicycle_ctrl #(.MEM_TIMEOUT(4), .ENABLE_M(1)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .mem_ready(mem_ready), .branch_taken(branch_taken), .mul_done(mul_done),
      .trap_ack(trap_ack), .ir_write(ir_write), .pc_write(pc_write),
      .reg_write(reg_write), .mem_req(mem_req), .mem_we(mem_we),
      .mem_is_instr(mem_is_instr), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
      .mul_start(mul_start), .alu_op(alu_op), .pc_src(pc_src),
      .illegal(illegal), .state_o(state_o)
   );

   multicycle_ctrl #(.MEM_TIMEOUT(4), .ENABLE_M(0)) dut_nm (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .mem_ready(mem_ready), .branch_taken(branch_taken), .mul_done(mul_done),
      .trap_ack(trap_ack), .ir_write(n_ir_write), .pc_write(n_pc_write),
      .reg_write(n_reg_write), .mem_req(n_mem_req), .mem_we(n_mem_we),
      .mem_is_instr(n_mem_is_instr), .mem_to_reg(n_mem_to_reg), .alu_src(n_alu_src),
      .mul_start(n_mul_start), .alu_op(n_alu_op), .pc_src(n_pc_src),
      .illegal(n_illegal), .state_o(n_state_o)
   );

   always #5 clk = ~clk;

   function automatic logic [18:0] ev(input logic [2:0] st, input logic [9:0] s,
                                      input logic [3:0] alu, input logic [1:0] pcs);
      return {s, alu, pcs, st};
   endfunction

   // Monitor: compares every queued expectation away from the active edge
   always @(negedge clk) begin
      logic [18:0] act, exp_v;
      logic [2:0]  exp_s0;
      string       nm;
      if (q_vec.size() > 0) begin
         exp_v  = q_vec.pop_front();
         exp_s0 = q_st0.pop_front();
         nm     = q_name.pop_front();
         act = {ir_write, pc_write, reg_write, mem_req, mem_we, mem_is_instr,
                mem_to_reg, alu_src, mul_start, illegal, alu_op, pc_src, state_o};
         checks++;
         if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: outputs got %05h want %05h", nm, act, exp_v);
         end
         checks++;
         if (n_state_o !== exp_s0) begin
            errors++;
            $display("FAIL %s nm: state got %0d want %0d", nm, n_state_o, exp_s0);
         end
      end
   end

   task automatic ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      opcode = op; funct3 = f3; funct7 = f7;
   endtask

   // One cycle of stimulus plus its expected response (main vector, no-M state)
   task automatic step(input logic mr, input logic bt, input logic md, input logic ta,
                       input logic [18:0] v, input logic [2:0] s0, input string nm);
      mem_ready = mr; branch_taken = bt; mul_done = md; trap_ack = ta;
      q_vec.push_back(v); q_st0.push_back(s0); q_name.push_back(nm);
      @(posedge clk); #1;
   endtask

   // Common fetch (ready in first cycle) and decode prologue
   task automatic fetch_decode(input string nm);
      step(1, 0, 0, 0, ev(3'd0, c_req | c_ins | c_irw, 4'd0, 2'd0), 3'd0, nm);
      step(0, 0, 0, 0, ev(3'd1, c_none, 4'd0, 2'd0), 3'd1, nm);
   endtask

   task automatic alu_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [3:0] alu, input logic src, input string nm);
      ir(op, f3, f7);
      fetch_decode(nm);
      step(0, 0, 0, 0, ev(3'd2, src ? c_src : c_none, alu, 2'd0), 3'd2, nm);
      step(0, 0, 0, 0, ev(3'd4, c_rw | c_pcw, 4'd0, 2'd0), 3'd4, nm);
   endtask

   initial begin
      rst_n = 1'b0;
      ir(7'b0110011, 3'b000, 7'h00);
      mem_ready = 0; branch_taken = 0; mul_done = 0; trap_ack = 0;
      @(posedge clk); #1;
      step(1, 0, 0, 0, ev(3'd0, c_none, 4'd0, 2'd0), 3'd0, "reset");
      step(0, 0, 0, 0, ev(3'd0, c_none, 4'd0, 2'd0), 3'd0, "reset");
      rst_n = 1'b1;

      // ADD x3,x1,x2 with instruction ready in the second fetch cycle
      ir(7'b0110011, 3'b000, 7'h00);
      step(0, 0, 0, 0, ev(3'd0, c_req | c_ins, 4'd0, 2'd0), 3'd0, "add_f1");
      step(1, 0, 0, 0, ev(3'd0, c_req | c_ins | c_irw, 4'd0, 2'd0), 3'd0, "add_f2");
      step(0, 0, 0, 0, ev(3'd1, c_none, 4'd0, 2'd0), 3'd1, "add_dec");
      step(0, 0, 0, 0, ev(3'd2, c_none, 4'b0000, 2'd0), 3'd2, "add_exec");
      step(0, 0, 0, 0, ev(3'd4, c_rw | c_pcw, 4'd0, 2'd0), 3'd4, "add_wb");

      alu_instr(7'b0110011, 3'b000, 7'h20, 4'b0001, 1'b0, "sub");
      alu_instr(7'b0110011, 3'b111, 7'h00, 4'b0010, 1'b0, "and");
      alu_instr(7'b0010011, 3'b101, 7'h20, 4'b0111, 1'b1, "srai");
      alu_instr(7'b0010011, 3'b011, 7'h00, 4'b1001, 1'b1, "sltiu");
      alu_instr(7'b0110111, 3'b000, 7'h00, 4'b0000, 1'b1, "lui");

      // LW: data ready on the fourth MEM cycle, exactly at the timeout limit
      ir(7'b0000011, 3'b010, 7'h00);
      fetch_decode("lw");
      step(0, 0, 0, 0, ev(3'd2, c_src, 4'd0, 2'd0), 3'd2, "lw_exec");
      step(0, 0, 0, 0, ev(3'd3, c_req, 4'd0, 2'd0), 3'd3, "lw_mem1");
      step(0, 0, 0, 0, ev(3'd3, c_req, 4'd0, 2'd0), 3'd3, "lw_mem2");
      step(0, 0, 0, 0, ev(3'd3, c_req, 4'd0, 2'd0), 3'd3, "lw_mem3");
      step(1, 0, 0, 0, ev(3'd3, c_req, 4'd0, 2'd0), 3'd3, "lw_mem4");
      step(0, 0, 0, 0, ev(3'd4, c_rw | c_pcw | c_m2r, 4'd0, 2'd0), 3'd4, "lw_wb");

      // SW completing normally
      ir(7'b0100011, 3'b010, 7'h00);
      fetch_decode("sw");
      step(0, 0, 0, 0, ev(3'd2, c_src, 4'd0, 2'd0), 3'd2, "sw_exec");
      step(1, 0, 0, 0, ev(3'd3, c_req | c_we | c_pcw, 4'd0, 2'd0), 3'd3, "sw_mem");

      // BEQ taken then not taken
      ir(7'b1100011, 3'b000, 7'h00);
      fetch_decode("beq_t");
      step(0, 1, 0, 0, ev(3'd2, c_pcw, 4'b0001, 2'b01), 3'd2, "beq_t_exec");
      fetch_decode("beq_n");
      step(0, 0, 0, 0, ev(3'd2, c_pcw, 4'b0001, 2'b00), 3'd2, "beq_n_exec");

      ir(7'b1101111, 3'b000, 7'h00);
      fetch_decode("jal");
      step(0, 0, 0, 0, ev(3'd2, c_rw | c_pcw, 4'd0, 2'b01), 3'd2, "jal_exec");
      ir(7'b1100111, 3'b000, 7'h00);
      fetch_decode("jalr");
      step(0, 0, 0, 0, ev(3'd2, c_rw | c_pcw, 4'd0, 2'b10), 3'd2, "jalr_exec");

      // Illegal R-type (funct7 0x20 with funct3 001); strobes ignored in TRAP
      ir(7'b0110011, 3'b001, 7'h20);
      fetch_decode("ill_r");
      step(1, 0, 1, 0, ev(3'd6, c_ill, 4'd0, 2'd0), 3'd6, "ill_r_trap");
      step(0, 0, 0, 1, ev(3'd6, c_ill, 4'd0, 2'd0), 3'd6, "ill_r_ack");

      ir(7'b1111111, 3'b000, 7'h00);
      fetch_decode("ill_op");
      step(0, 0, 0, 1, ev(3'd6, c_ill, 4'd0, 2'd0), 3'd6, "ill_op_ack");

      // Fetch timeout: four cycles without ready, then TRAP
      for (int i = 0; i < 4; i++)
         step(0, 0, 0, 0, ev(3'd0, c_req | c_ins, 4'd0, 2'd0), 3'd0, "tmo_fetch");
      step(0, 0, 0, 0, ev(3'd6, c_ill, 4'd0, 2'd0), 3'd6, "tmo_trap");
      step(0, 0, 0, 1, ev(3'd6, c_ill, 4'd0, 2'd0), 3'd6, "tmo_ack");

      // MUL: M-enabled copy waits on mul_done, M-disabled copy traps
      ir(7'b0110011, 3'b000, 7'h01);
      fetch_decode("mul");
      step(0, 0, 0, 0, ev(3'd2, c_mst, 4'b1010, 2'd0), 3'd6, "mul_exec");
      step(0, 0, 0, 0, ev(3'd5, c_none, 4'b1010, 2'd0), 3'd6, "mul_wait1");
      step(0, 0, 1, 0, ev(3'd5, c_none, 4'b1010, 2'd0), 3'd6, "mul_wait2");
      step(0, 0, 0, 1, ev(3'd4, c_rw | c_pcw, 4'd0, 2'd0), 3'd6, "mul_wb");

      // M funct3 100 is illegal even with M enabled
      ir(7'b0110011, 3'b100, 7'h01);
      fetch_decode("div");
      step(0, 0, 0, 1, ev(3'd6, c_ill, 4'd0, 2'd0), 3'd6, "div_trap");

      // Reset asserted in the middle of a store access
      ir(7'b0100011, 3'b010, 7'h00);
      fetch_decode("sw_rst");
      step(0, 0, 0, 0, ev(3'd2, c_src, 4'd0, 2'd0), 3'd2, "sw_rst_exec");
      step(0, 0, 0, 0, ev(3'd3, c_req | c_we, 4'd0, 2'd0), 3'd3, "sw_rst_mem");
      rst_n = 1'b0;
      step(1, 0, 0, 0, ev(3'd0, c_none, 4'd0, 2'd0), 3'd0, "sw_rst_low");
      step(0, 0, 0, 0, ev(3'd0, c_none, 4'd0, 2'd0), 3'd0, "sw_rst_low2");
      rst_n = 1'b1;
      step(0, 0, 0, 0, ev(3'd0, c_req | c_ins, 4'd0, 2'd0), 3'd0, "post_rst_fetch");

      for (int i = 0; i < 10 && q_vec.size() > 0; i++) @(posedge clk);
      if (q_vec.size() > 0) begin
         errors++;
         $display("FAIL drain: pending %0d want 0", q_vec.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, meaning the maximum cycles a memory request waits for mem_ready before trapping (range 1..255).
REQ-002 SHALL have parameter ENABLE_M, default 0, meaning that when 1, RV32M MUL/MULH/MULHSU/MULHU decode and multi-cycle wait are enabled.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 opcode  in  7  instruction-register opcode field.
REQ-006 funct3  in  3  instruction-register funct3 field.
REQ-007 funct7  in  7  instruction-register funct7 field.
REQ-008 mem_ready  in  1  memory completion strobe, one cycle per request.
REQ-009 branch_taken  in  1  datapath branch-condition result, valid in EXEC.
REQ-010 mul_done  in  1  multiplier completion strobe (ignored when ENABLE_M=0).
REQ-011 trap_ack  in  1  single-cycle clear of the TRAP state.
REQ-012 ir_write, pc_write, reg_write, mem_req, mem_we, mem_is_instr, mem_to_reg, alu_src, mul_start  out  1 each  datapath strobes and selects.
REQ-013 alu_op  out  4  ALU operation code; pc_src  out  2  (00 pc+4, 01 pc+imm, 10 rs1+imm).
REQ-014 illegal  out  1  high while in TRAP; state_o  out  3  current state encoding.

Function
REQ-015 SHALL implement the FSM states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MULWAIT=5, TRAP=6, all encoded as 3 bits.
REQ-016 All outputs SHALL be Moore/Mealy combinational from state and inputs; outputs not listed for a state SHALL be 0.
REQ-017 FETCH: mem_req=1 and mem_is_instr=1; on mem_ready, ir_write=1 in that same cycle and the next state SHALL be DECODE.
REQ-018 DECODE: legal opcodes are 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, and 0010111; any other opcode, an R-type with funct7 not in {0x00, 0x20}, or 0x20 with funct3 not in {000, 101}, SHALL go to TRAP; otherwise the FSM SHALL go to EXEC.
REQ-019 ALU codes SHALL be ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001; with ENABLE_M=1, MUL 1010, MULH 1011, MULHSU 1100, and MULHU 1101 SHALL be decoded for funct7=0x01 with funct3 000..011, and funct7=0x01 with funct3 100..111 SHALL be illegal.
REQ-020 With ENABLE_M=0, funct7=0x01 SHALL be illegal.
REQ-021 EXEC R/I-type, LUI, and AUIPC: alu_op decoded, alu_src=1 for non-R types, next state WB; for I-type funct3=101, funct7=0x20 SHALL select SRA.
REQ-022 EXEC load/store: alu_op=ADD, alu_src=1, next state MEM.
REQ-023 EXEC branch: alu_op=SUB; pc_write=1 with pc_src=01 when branch_taken=1, otherwise pc_write=1 with pc_src=00; next state FETCH.
REQ-024 EXEC JAL/JALR: reg_write=1 and pc_write=1 with pc_src 01 for JAL or 10 for JALR; next state FETCH.
REQ-025 EXEC M-op: mul_start=1 for exactly one cycle, next state MULWAIT; MULWAIT SHALL hold alu_op and, on mul_done, go to WB.
REQ-026 MEM: mem_req=1, mem_we=1 for store; on mem_ready, a load SHALL go to WB and a store SHALL assert pc_write=1 with pc_src=00 and go to FETCH.
REQ-027 WB: reg_write=1, mem_to_reg=1 for load, pc_write=1 with pc_src=00; next state FETCH.
REQ-028 An 8-bit wait counter SHALL clear on every state change and increment each cycle in FETCH/MEM without mem_ready; reaching MEM_TIMEOUT-1 without mem_ready SHALL go to TRAP next cycle.
REQ-029 mem_ready arriving in the same cycle the counter hits its limit SHALL complete the access (ready wins).
REQ-030 TRAP: illegal=1, no strobes; trap_ack SHALL go to FETCH; mem_ready/mul_done in TRAP SHALL be ignored.
REQ-031 mem_ready and mul_done outside their waiting states SHALL be ignored.

Reset
REQ-032 While rst_n=0 the state SHALL be FETCH, the counter 0, and all strobe outputs 0 (state_o=0), asynchronously, including mid-access.
REQ-033 The first mem_req SHALL assert in the first cycle after rst_n deasserts.

Structure
REQ-034 The opcode constants, alu_op codes, pc_src codes, and state encodings SHALL live in a shared package rv_ctrl_pkg reused by datapath and ALU.
REQ-035 Combinational decode (opcode/funct → alu_op, class, legal) SHALL be a sub-module rv_decode; the FSM and counter SHALL stay in multicycle_ctrl.

Verification
REQ-036 ADD x3,x1,x2 (0x002081B3), mem_ready at fetch cycle 2 -> FETCH,FETCH,DECODE,EXEC(alu_op=0000),WB(reg_write=1,pc_write=1), then FETCH.
REQ-037 LW (opcode 0000011), data mem_ready after 3 cycles -> MEM held 4 cycles with mem_req=1, mem_we=0, then WB with mem_to_reg=1.
REQ-038 BEQ with branch_taken=1 -> EXEC alu_op=0001, pc_write=1, pc_src=01; with branch_taken=0 -> pc_src=00.
REQ-039 MEM_TIMEOUT=4, no mem_ready in FETCH -> TRAP after 4 cycles, illegal=1; trap_ack -> FETCH.
REQ-040 funct7=0x01, funct3=000: ENABLE_M=0 -> TRAP; ENABLE_M=1 -> mul_start pulse, MULWAIT until mul_done, alu_op=1010.
REQ-041 rst_n pulsed low during MEM with a store -> mem_we drops immediately, state_o=0, and a fresh fetch follows release.
